// File: rtl/avalon_req_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// avalon_arb_pkg
//   Shared types and helpers for the two-requester Avalon-MM arbiter.
//
//   state_t  : FSM encoding (IDLE -> BUS -> RESP -> IDLE)
//   grant_t  : which requester owns the bus (GNT_I = fetch, GNT_D = load/store)
//   TO_W     : timeout counter width for the default TIMEOUT of 1023
//   to_width : timeout counter width for any TIMEOUT (never narrower than 1)
// -----------------------------------------------------------------------------
package avalon_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    localparam int TIMEOUT_DEFAULT = 1023;
    localparam int TO_W            = $clog2(TIMEOUT_DEFAULT + 1);

    // A disabled timeout (0) still needs a 1-bit counter so the register
    // declaration stays legal.
    function automatic int to_width(input int timeout);
        if (timeout < 1) begin
            return 1;
        end
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/avalon_req_arbiter_if.sv
// -----------------------------------------------------------------------------
// avalon_req_arbiter_if
//   Bundles the two requester handshakes and the shared Avalon-MM master bus.
//
//   Requester handshake (I and D): req is a level. Once req is raised, addr,
//   rnw, wdata and lock stay stable until the arbiter returns a one-cycle done
//   pulse; rdata and err are valid only in that done cycle. Req drops in the
//   cycle after done, or stays high to ask for a back-to-back transfer.
//
//   Avalon side: READ/WRITE with ADDRESS/WRITEDATA are held while WAITREQUEST
//   is high; the cycle with WAITREQUEST low completes the transfer and
//   READDATA is sampled in that cycle. BEGINTRANSFER marks the first bus cycle.
//
//   modport master : the arbiter
//   modport slave  : the environment (core requesters + interconnect)
// -----------------------------------------------------------------------------
interface avalon_req_arbiter_if #(
    parameter int WIDTH = 32
);

    // instruction fetch requester
    logic             i_req;
    logic [WIDTH-1:0] i_addr;
    logic             i_done;

    // load/store requester
    logic             d_req;
    logic             d_rnw;
    logic [WIDTH-1:0] d_addr;
    logic [WIDTH-1:0] d_wdata;
    logic             d_lock;
    logic             d_done;

    // shared response
    logic [WIDTH-1:0] rdata;
    logic             err;

    // Avalon-MM master
    logic [WIDTH-1:0] ADDRESS;
    logic             READ;
    logic             WRITE;
    logic [WIDTH-1:0] WRITEDATA;
    logic             BEGINTRANSFER;
    logic             LOCK;
    logic [WIDTH-1:0] READDATA;
    logic             WAITREQUEST;

    modport master (
        input  i_req, i_addr,
        input  d_req, d_rnw, d_addr, d_wdata, d_lock,
        input  READDATA, WAITREQUEST,
        output i_done, d_done, rdata, err,
        output ADDRESS, READ, WRITE, WRITEDATA, BEGINTRANSFER, LOCK
    );

    modport slave (
        output i_req, i_addr,
        output d_req, d_rnw, d_addr, d_wdata, d_lock,
        output READDATA, WAITREQUEST,
        input  i_done, d_done, rdata, err,
        input  ADDRESS, READ, WRITE, WRITEDATA, BEGINTRANSFER, LOCK
    );

endinterface

// File: rtl/avalon_req_arbiter_select.sv
// -----------------------------------------------------------------------------
// avalon_arb_select
//   Combinational winner picker for the shared master.
//
//   Ports:
//     i_req, d_req  : requester levels
//     last_grant    : owner of the previous completed transfer
//     lock          : current Avalon LOCK; while set only D may win
//     gnt_valid     : some requester may be granted this cycle
//     gnt_winner    : which one (meaningful only with gnt_valid)
//
//   FAIR != 0 breaks ties toward the requester that did not go last;
//   FAIR == 0 gives D every tie.
// -----------------------------------------------------------------------------
module avalon_arb_select
    import avalon_arb_pkg::*;
#(
    parameter int FAIR = 1
) (
    input  logic   i_req,
    input  logic   d_req,
    input  grant_t last_grant,
    input  logic   lock,
    output logic   gnt_valid,
    output grant_t gnt_winner
);

    always_comb begin
        gnt_valid  = 1'b0;
        gnt_winner = GNT_D;
        if (lock) begin
            // A locked sequence belongs to D; I waits even if D has gone quiet.
            gnt_valid  = d_req;
            gnt_winner = GNT_D;
        end else if (i_req && d_req) begin
            gnt_valid = 1'b1;
            if ((FAIR != 0) && (last_grant == GNT_D)) begin
                gnt_winner = GNT_I;
            end else begin
                gnt_winner = GNT_D;
            end
        end else if (i_req) begin
            gnt_valid  = 1'b1;
            gnt_winner = GNT_I;
        end else if (d_req) begin
            gnt_valid  = 1'b1;
            gnt_winner = GNT_D;
        end
    end

endmodule

// File: rtl/avalon_req_arbiter.sv
// -----------------------------------------------------------------------------
// avalon_req_arbiter
//   One Avalon-MM master shared by the instruction-fetch (I) and load/store (D)
//   requesters of the core.
//
//   Ports:
//     CLK, RST_N : clock, asynchronous active-low reset
//     bus        : requester handshakes + Avalon master (interface, master)
//     dbg_state  : current FSM state (IDLE=0, BUS=1, RESP=2)
//
//   Parameters:
//     WIDTH   : address/data width
//     FAIR    : 1 = round-robin on ties, 0 = D always wins ties
//     TIMEOUT : WAITREQUEST stall cycles before the transfer is aborted,
//               0 = never abort
//
//   Flow: IDLE picks a winner and loads the bus registers; BUS holds them
//   while WAITREQUEST is high; completion (or abort) loads rdata/err and the
//   winner's done pulse, which are visible during the single RESP cycle.
//   Zero-wait-state transfers therefore take three cycles.
// -----------------------------------------------------------------------------
module avalon_req_arbiter
    import avalon_arb_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int FAIR    = 1,
    parameter int TIMEOUT = 1023
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    avalon_req_arbiter_if.master bus,
    output logic [1:0]           dbg_state
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_BUS  = BUS;
    localparam logic [1:0] ST_RESP = RESP;

    localparam int CNT_W = to_width(TIMEOUT);

    logic [1:0]       state;
    grant_t           last_grant;
    grant_t           winner;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   cnt_inc;
    logic             timeout_hit;
    logic             gnt_valid;
    grant_t           gnt_winner;

    avalon_arb_select #(
        .FAIR (FAIR)
    ) u_select (
        .i_req      (bus.i_req),
        .d_req      (bus.d_req),
        .last_grant (last_grant),
        .lock       (bus.LOCK),
        .gnt_valid  (gnt_valid),
        .gnt_winner (gnt_winner)
    );

    // The abort fires in the stall cycle that would bring the count to
    // TIMEOUT, so READ/WRITE are seen high for exactly TIMEOUT stalled cycles
    // and the error done follows in the next cycle.
    assign cnt_inc     = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == (CNT_W + 1)'(TIMEOUT));

    assign dbg_state = state;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state             <= ST_IDLE;
            last_grant        <= GNT_I;
            winner            <= GNT_I;
            cnt               <= '0;
            bus.ADDRESS       <= '0;
            bus.READ          <= 1'b0;
            bus.WRITE         <= 1'b0;
            bus.WRITEDATA     <= '0;
            bus.BEGINTRANSFER <= 1'b0;
            bus.LOCK          <= 1'b0;
            bus.i_done        <= 1'b0;
            bus.d_done        <= 1'b0;
            bus.rdata         <= '0;
            bus.err           <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // LOCK follows d_lock of each D grant; any IDLE cycle that
                    // does not start a locked D transfer releases it. When
                    // locked, the selector only grants D, so an I grant here
                    // always happens with LOCK already clear.
                    bus.LOCK <= gnt_valid && (gnt_winner == GNT_D) && bus.d_lock;
                    if (gnt_valid) begin
                        winner            <= gnt_winner;
                        cnt               <= '0;
                        bus.BEGINTRANSFER <= 1'b1;
                        state             <= ST_BUS;
                        if (gnt_winner == GNT_D) begin
                            bus.ADDRESS   <= bus.d_addr;
                            bus.READ      <= bus.d_rnw;
                            bus.WRITE     <= ~bus.d_rnw;
                            bus.WRITEDATA <= bus.d_wdata;
                        end else begin
                            bus.ADDRESS   <= bus.i_addr;
                            bus.READ      <= 1'b1;
                            bus.WRITE     <= 1'b0;
                            bus.WRITEDATA <= '0;
                        end
                    end
                end

                ST_BUS: begin
                    bus.BEGINTRANSFER <= 1'b0;
                    if (!bus.WAITREQUEST) begin
                        // Writes return 0 so rdata never shows stale read data
                        // alongside a write completion.
                        bus.rdata <= bus.READ ? bus.READDATA : '0;
                        bus.READ  <= 1'b0;
                        bus.WRITE <= 1'b0;
                        if (winner == GNT_D) begin
                            bus.d_done <= 1'b1;
                        end else begin
                            bus.i_done <= 1'b1;
                        end
                        state <= ST_RESP;
                    end else if (timeout_hit) begin
                        bus.rdata <= '0;
                        bus.err   <= 1'b1;
                        bus.READ  <= 1'b0;
                        bus.WRITE <= 1'b0;
                        if (winner == GNT_D) begin
                            bus.d_done <= 1'b1;
                        end else begin
                            bus.i_done <= 1'b1;
                        end
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt_inc[CNT_W-1:0];
                    end
                end

                ST_RESP: begin
                    // No arbitration here: a req still high now is only seen
                    // in the following IDLE cycle.
                    bus.i_done <= 1'b0;
                    bus.d_done <= 1'b0;
                    bus.err    <= 1'b0;
                    last_grant <= winner;
                    state      <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_avalon_req_arbiter
//   Directed bench for avalon_req_arbiter. dut_a runs round-robin with a
//   4-cycle timeout; dut_b runs fixed priority with the timeout disabled.
//   Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_avalon_req_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_a;
    logic [1:0] dbg_b;

    int n_cmp = 0;
    int n_mis = 0;

    avalon_req_arbiter_if #(.WIDTH(32)) ifa ();
    avalon_req_arbiter_if #(.WIDTH(32)) ifb ();

    avalon_req_arbiter #(
        .WIDTH   (32),
        .FAIR    (1),
        .TIMEOUT (4)
    ) dut_a (
        .CLK       (clk),
        .RST_N     (rst_n),
        .bus       (ifa.master),
        .dbg_state (dbg_a)
    );

    avalon_req_arbiter #(
        .WIDTH   (32),
        .FAIR    (0),
        .TIMEOUT (0)
    ) dut_b (
        .CLK       (clk),
        .RST_N     (rst_n),
        .bus       (ifb.master),
        .dbg_state (dbg_b)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ifa.i_req = 0; ifa.i_addr = 0; ifa.d_req = 0; ifa.d_rnw = 0;
        ifa.d_addr = 0; ifa.d_wdata = 0; ifa.d_lock = 0;
        ifa.READDATA = 0; ifa.WAITREQUEST = 0;
        ifb.i_req = 0; ifb.i_addr = 0; ifb.d_req = 0; ifb.d_rnw = 0;
        ifb.d_addr = 0; ifb.d_wdata = 0; ifb.d_lock = 0;
        ifb.READDATA = 0; ifb.WAITREQUEST = 0;

        // ---- reset state
        repeat (3) step;
        check("rst_read",   32'(ifa.READ), 32'd0);
        check("rst_write",  32'(ifa.WRITE), 32'd0);
        check("rst_addr",   ifa.ADDRESS, 32'd0);
        check("rst_begin",  32'(ifa.BEGINTRANSFER), 32'd0);
        check("rst_lock",   32'(ifa.LOCK), 32'd0);
        check("rst_done",   32'({ifa.i_done, ifa.d_done}), 32'd0);
        check("rst_rdata",  ifa.rdata, 32'd0);
        check("rst_err",    32'(ifa.err), 32'd0);
        check("rst_state",  32'(dbg_a), 32'd0);
        check("rst_b_read", 32'(ifb.READ), 32'd0);
        rst_n = 1'b1;

        // ---- I read, zero wait states
        ifa.i_req = 1; ifa.i_addr = 32'h100;
        ifa.READDATA = 32'hDEADBEEF; ifa.WAITREQUEST = 0;
        step;
        check("t1_read",   32'(ifa.READ), 32'd1);
        check("t1_write",  32'(ifa.WRITE), 32'd0);
        check("t1_begin",  32'(ifa.BEGINTRANSFER), 32'd1);
        check("t1_addr",   ifa.ADDRESS, 32'h100);
        check("t1_nodone", 32'(ifa.i_done), 32'd0);
        step;
        check("t1_idone",  32'(ifa.i_done), 32'd1);
        check("t1_ddone",  32'(ifa.d_done), 32'd0);
        check("t1_rdata",  ifa.rdata, 32'hDEADBEEF);
        check("t1_err",    32'(ifa.err), 32'd0);
        check("t1_readlo", 32'(ifa.READ), 32'd0);
        step;
        ifa.i_req = 0;
        check("t1_pulse",  32'(ifa.i_done), 32'd0);
        check("t1_hold",   ifa.rdata, 32'hDEADBEEF);
        check("t1_idle",   32'(dbg_a), 32'd0);

        // ---- D write with three stall cycles
        ifa.d_req = 1; ifa.d_rnw = 0; ifa.d_addr = 32'h2000;
        ifa.d_wdata = 32'h55AA; ifa.WAITREQUEST = 1;
        step;
        check("t2_write1", 32'(ifa.WRITE), 32'd1);
        check("t2_read1",  32'(ifa.READ), 32'd0);
        check("t2_begin1", 32'(ifa.BEGINTRANSFER), 32'd1);
        check("t2_addr1",  ifa.ADDRESS, 32'h2000);
        check("t2_wdata1", ifa.WRITEDATA, 32'h55AA);
        step;
        check("t2_write2", 32'(ifa.WRITE), 32'd1);
        check("t2_begin2", 32'(ifa.BEGINTRANSFER), 32'd0);
        check("t2_addr2",  ifa.ADDRESS, 32'h2000);
        check("t2_wdata2", ifa.WRITEDATA, 32'h55AA);
        step;
        check("t2_write3", 32'(ifa.WRITE), 32'd1);
        check("t2_done3",  32'(ifa.d_done), 32'd0);
        step;
        check("t2_write4", 32'(ifa.WRITE), 32'd1);
        check("t2_begin4", 32'(ifa.BEGINTRANSFER), 32'd0);
        check("t2_done4",  32'(ifa.d_done), 32'd0);
        ifa.WAITREQUEST = 0;
        step;
        check("t2_ddone",  32'(ifa.d_done), 32'd1);
        check("t2_idone",  32'(ifa.i_done), 32'd0);
        check("t2_wrlo",   32'(ifa.WRITE), 32'd0);
        check("t2_rdata",  ifa.rdata, 32'd0);
        check("t2_err",    32'(ifa.err), 32'd0);
        step;
        ifa.d_req = 0;
        check("t2_pulse",  32'(ifa.d_done), 32'd0);

        // ---- both requesters held high: round-robin vs fixed priority
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        ifa.i_req = 1; ifa.i_addr = 32'h100;
        ifa.d_req = 1; ifa.d_rnw = 1; ifa.d_addr = 32'h3000; ifa.d_lock = 0;
        ifa.READDATA = 32'h12345678; ifa.WAITREQUEST = 0;
        ifb.i_req = 1; ifb.i_addr = 32'h100;
        ifb.d_req = 1; ifb.d_rnw = 1; ifb.d_addr = 32'h3000; ifb.d_lock = 0;
        ifb.READDATA = 32'h12345678; ifb.WAITREQUEST = 0;
        for (int k = 0; k < 4; k++) begin
            // last_grant starts at I, so D goes first: D, I, D, I
            logic exp_d;
            exp_d = ((k % 2) == 0);
            step;
            check("rr_addr", ifa.ADDRESS, exp_d ? 32'h3000 : 32'h100);
            check("fp_addr", ifb.ADDRESS, 32'h3000);
            step;
            check("rr_ddone", 32'(ifa.d_done), 32'(exp_d));
            check("rr_idone", 32'(ifa.i_done), 32'(!exp_d));
            check("fp_ddone", 32'(ifb.d_done), 32'd1);
            check("fp_idone", 32'(ifb.i_done), 32'd0);
            step;
        end
        ifb.i_req = 0; ifb.d_req = 0;

        // ---- locked D pair while I waits (last_grant is I here)
        ifa.d_lock = 1; ifa.d_addr = 32'h4000;
        step;
        check("lk_addr1",  ifa.ADDRESS, 32'h4000);
        check("lk_lock1",  32'(ifa.LOCK), 32'd1);
        step;
        check("lk_done1",  32'(ifa.d_done), 32'd1);
        step;
        check("lk_lockid", 32'(ifa.LOCK), 32'd1);
        step;
        check("lk_addr2",  ifa.ADDRESS, 32'h4000);
        check("lk_lock2",  32'(ifa.LOCK), 32'd1);
        step;
        check("lk_done2",  32'(ifa.d_done), 32'd1);
        check("lk_nocross", 32'(ifa.i_done), 32'd0);
        step;
        ifa.d_req = 0; ifa.d_lock = 0;
        check("lk_still",  32'(ifa.LOCK), 32'd1);
        step;
        check("lk_clear",  32'(ifa.LOCK), 32'd0);
        check("lk_idle",   32'(dbg_a), 32'd0);
        check("lk_noread", 32'(ifa.READ), 32'd0);
        step;
        check("lk_igrant", ifa.ADDRESS, 32'h100);
        check("lk_iread",  32'(ifa.READ), 32'd1);
        check("lk_unlock", 32'(ifa.LOCK), 32'd0);
        step;
        check("lk_idone",  32'(ifa.i_done), 32'd1);
        check("lk_rdata",  ifa.rdata, 32'h12345678);
        step;

        // ---- timeout after 4 stalled cycles
        ifa.i_req = 1; ifa.i_addr = 32'h500;
        ifa.WAITREQUEST = 1; ifa.READDATA = 32'hCAFEF00D;
        step;
        check("to_read1",  32'(ifa.READ), 32'd1);
        check("to_begin1", 32'(ifa.BEGINTRANSFER), 32'd1);
        step;
        check("to_read2",  32'(ifa.READ), 32'd1);
        step;
        check("to_read3",  32'(ifa.READ), 32'd1);
        step;
        check("to_read4",  32'(ifa.READ), 32'd1);
        check("to_nodone", 32'(ifa.i_done), 32'd0);
        step;
        check("to_readlo", 32'(ifa.READ), 32'd0);
        check("to_idone",  32'(ifa.i_done), 32'd1);
        check("to_err",    32'(ifa.err), 32'd1);
        check("to_rdata",  ifa.rdata, 32'd0);
        check("to_resp",   32'(dbg_a), 32'd2);
        step;
        check("to_errlo",  32'(ifa.err), 32'd0);
        check("to_pulse",  32'(ifa.i_done), 32'd0);
        check("to_idle",   32'(dbg_a), 32'd0);
        ifa.i_req = 0; ifa.WAITREQUEST = 0;

        // ---- reset in the second BUS cycle
        ifa.i_req = 1; ifa.i_addr = 32'h600;
        ifa.WAITREQUEST = 1; ifa.READDATA = 32'h0BADF00D;
        step;
        check("rs_read1",  32'(ifa.READ), 32'd1);
        step;
        check("rs_read2",  32'(ifa.READ), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rs_readlo", 32'(ifa.READ), 32'd0);
        check("rs_addrlo", ifa.ADDRESS, 32'd0);
        check("rs_beginlo", 32'(ifa.BEGINTRANSFER), 32'd0);
        check("rs_state",  32'(dbg_a), 32'd0);
        check("rs_nodone", 32'(ifa.i_done), 32'd0);
        step;
        check("rs_nodone2", 32'(ifa.i_done), 32'd0);
        ifa.WAITREQUEST = 0;
        rst_n = 1'b1;
        step;
        check("rs_read",   32'(ifa.READ), 32'd1);
        check("rs_begin",  32'(ifa.BEGINTRANSFER), 32'd1);
        check("rs_addr",   ifa.ADDRESS, 32'h600);
        step;
        check("rs_idone",  32'(ifa.i_done), 32'd1);
        check("rs_rdata",  ifa.rdata, 32'h0BADF00D);
        check("rs_err",    32'(ifa.err), 32'd0);
        step;
        ifa.i_req = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
